// File: rtl/addr8u_operand_seq.sv
// Operand sequencer for an external 8-bit adder: latch, settle, capture, hold.
// Optional golden-sum checker compiled in with ADDR8U_SELFCHK_EN.
module addr8u_operand_seq #(
   parameter int unsigned SETTLE_CYCLES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] in_a,
   input  logic [7:0] in_b,
   output logic [7:0] add_a,
   output logic [7:0] add_b,
   input  logic [8:0] add_sum,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [8:0] out_sum,
   output logic       err_flag,
   output logic [7:0] err_cnt
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      HOLD   = 2'd2
   } state_t;

   localparam logic [3:0] CNT_LD = 4'(SETTLE_CYCLES - 1);

   state_t     state_q, state_d;
   logic [7:0] a_q, a_d;
   logic [7:0] b_q, b_d;
   logic [3:0] cnt_q, cnt_d;
   logic [8:0] sum_q, sum_d;
   logic       vld_q, vld_d;
   logic       accept;

   assign in_ready  = (state_q == IDLE) ||
                      ((state_q == HOLD) && out_ready);
   assign accept    = in_valid && in_ready;
   assign add_a     = a_q;
   assign add_b     = b_q;
   assign out_valid = vld_q;
   assign out_sum   = sum_q;

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      cnt_d   = cnt_q;
      sum_d   = sum_q;
      vld_d   = vld_q;
      unique case (state_q)
         IDLE: ;
         SETTLE: begin
            if (cnt_q == 4'd0) begin
               sum_d   = add_sum;
               vld_d   = 1'b1;
               state_d = HOLD;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         HOLD: begin
            if (out_ready) begin
               vld_d   = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      // A drain-and-accept in HOLD overrides the return to IDLE
      if (accept) begin
         a_d     = in_a;
         b_d     = in_b;
         cnt_d   = CNT_LD;
         state_d = SETTLE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         cnt_q   <= '0;
         sum_q   <= '0;
         vld_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         cnt_q   <= cnt_d;
         sum_q   <= sum_d;
         vld_q   <= vld_d;
      end
   end

`ifdef ADDR8U_SELFCHK_EN
   logic       cap;
   logic       miss;
   logic [8:0] gold;
   logic       eflag_q;
   logic [7:0] ecnt_q;

   assign cap  = (state_q == SETTLE) && (cnt_q == 4'd0);
   assign gold = {1'b0, a_q} + {1'b0, b_q};
   assign miss = cap && (add_sum != gold);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         eflag_q <= 1'b0;
         ecnt_q  <= '0;
      end else if (miss) begin
         eflag_q <= 1'b1;
         if (ecnt_q != 8'hFF) ecnt_q <= ecnt_q + 8'd1;
      end
   end

   assign err_flag = eflag_q;
   assign err_cnt  = ecnt_q;
`else
   assign err_flag = 1'b0;
   assign err_cnt  = '0;
`endif

endmodule

// File: tb/tb_addr8u_operand_seq.sv
// Directed bench for addr8u_operand_seq with a behavioural adder model.
// Fault injection flips sum bit 0 when fault is high.
module tb_addr8u_operand_seq;

   localparam int ST = 2;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid, in_ready;
   logic [7:0] in_a, in_b, add_a, add_b;
   logic [8:0] add_sum, out_sum;
   logic       out_valid, out_ready;
   logic       err_flag;
   logic [7:0] err_cnt;
   logic       fault;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   assign add_sum = ({1'b0, add_a} + {1'b0, add_b}) ^ {8'd0, fault};

   addr8u_operand_seq #(.SETTLE_CYCLES(ST)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b),
      .add_a(add_a), .add_b(add_b), .add_sum(add_sum),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_sum(out_sum),
      .err_flag(err_flag), .err_cnt(err_cnt)
   );

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [8:0] s;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   // Accept a pair from IDLE and wait (bounded) for out_valid
   task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                         output logic [8:0] s, output int lat);
      @(negedge clk);
      in_a = a; in_b = b; in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      s = out_sum;
   endtask

   task automatic drain;
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   initial begin
      logic [8:0] s;
      int lat;
      vecs[0] = '{8'h5A, 8'h3C, 9'h096};
      vecs[1] = '{8'hFF, 8'hFF, 9'h1FE};
      vecs[2] = '{8'h00, 8'h00, 9'h000};
      vecs[3] = '{8'h80, 8'h80, 9'h100};
      vecs[4] = '{8'h01, 8'hFE, 9'h0FF};
      vecs[5] = '{8'hA5, 8'h5B, 9'h100};

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_a = 8'h00; in_b = 8'h00; fault = 1'b0;
      #12;
      chk("rst in_ready", 32'(in_ready), 1);
      chk("rst out_valid", 32'(out_valid), 0);
      chk("rst add_a", 32'(add_a), 0);
      chk("rst add_b", 32'(add_b), 0);
      chk("rst out_sum", 32'(out_sum), 0);
      chk("rst err_flag", 32'(err_flag), 0);
      chk("rst err_cnt", 32'(err_cnt), 0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 6; i++) begin
         run_op(vecs[i].a, vecs[i].b, s, lat);
         chk($sformatf("vec%0d sum", i), 32'(s), 32'(vecs[i].s));
         chk($sformatf("vec%0d lat", i), lat, ST);
         chk($sformatf("vec%0d add_a", i), 32'(add_a), 32'(vecs[i].a));
         chk($sformatf("vec%0d err", i), 32'(err_flag), 0);
         drain();
         chk($sformatf("vec%0d drained", i), 32'(out_valid), 0);
         chk($sformatf("vec%0d rdy", i), 32'(in_ready), 1);
      end

      // Hold with back-pressure, then same-edge drain and accept
      run_op(8'h10, 8'h20, s, lat);
      chk("hold first sum", 32'(s), 9'h030);
      @(negedge clk);
      in_valid = 1'b1; in_a = 8'h77; in_b = 8'h66;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         chk("hold sum", 32'(out_sum), 9'h030);
         chk("hold valid", 32'(out_valid), 1);
         chk("hold in_ready", 32'(in_ready), 0);
         chk("hold add_a", 32'(add_a), 8'h10);
      end
      @(negedge clk);
      in_a = 8'h01; in_b = 8'h02; out_ready = 1'b1;
      @(posedge clk); #1;
      chk("swap valid", 32'(out_valid), 0);
      chk("swap add_a", 32'(add_a), 8'h01);
      chk("swap add_b", 32'(add_b), 8'h02);
      in_a = 8'hEE; in_b = 8'hDD; out_ready = 1'b0;
      chk("settle in_ready", 32'(in_ready), 0);
      @(posedge clk); #1;
      chk("settle ignores a", 32'(add_a), 8'h01);
      in_valid = 1'b0;
      @(posedge clk); #1;
      chk("swap out_valid", 32'(out_valid), 1);
      chk("swap sum", 32'(out_sum), 9'h003);
      drain();

      // Reset mid-SETTLE discards the operation
      @(negedge clk);
      in_a = 8'h33; in_b = 8'h44; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("pre-rst add_a", 32'(add_a), 8'h33);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rst async add_a", 32'(add_a), 0);
      chk("rst async add_b", 32'(add_b), 0);
      chk("rst async rdy", 32'(in_ready), 1);
      @(negedge clk);
      rst_n = 1'b1;
      in_a = 8'h21; in_b = 8'h12; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("post-rst accept", 32'(add_a), 8'h21);
      @(posedge clk); #1;
      chk("post-rst no valid", 32'(out_valid), 0);
      @(posedge clk); #1;
      chk("post-rst sum", 32'(out_sum), 9'h033);
      drain();

      // Reset mid-SETTLE then idle: no stray out_valid
      @(negedge clk);
      in_a = 8'h09; in_b = 8'h09; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         chk("idle after rst valid", 32'(out_valid), 0);
      end

      // Faulty adder
      fault = 1'b1;
      run_op(8'h10, 8'h01, s, lat);
      chk("fault sum", 32'(s), 9'h010);
`ifdef ADDR8U_SELFCHK_EN
      chk("fault flag", 32'(err_flag), 1);
      chk("fault cnt", 32'(err_cnt), 1);
`else
      chk("fault flag off", 32'(err_flag), 0);
      chk("fault cnt off", 32'(err_cnt), 0);
`endif
      drain();
      for (int i = 0; i < 300; i++) begin
         run_op(8'(i), 8'h03, s, lat);
         drain();
      end
`ifdef ADDR8U_SELFCHK_EN
      chk("sat cnt", 32'(err_cnt), 255);
`else
      chk("sat cnt off", 32'(err_cnt), 0);
`endif
      fault = 1'b0;
      run_op(8'h02, 8'h02, s, lat);
      chk("good after fault", 32'(s), 9'h004);
`ifdef ADDR8U_SELFCHK_EN
      chk("sticky flag", 32'(err_flag), 1);
`else
      chk("sticky flag off", 32'(err_flag), 0);
`endif
      drain();
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("err flag cleared", 32'(err_flag), 0);
      chk("err cnt cleared", 32'(err_cnt), 0);
      @(negedge clk);
      rst_n = 1'b1;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
